// File: rtl/rhythm_pkg.sv
// rhythm_pkg: shared definitions for the rhythm recorder.
//   state_t      - capture FSM states
//   CODE_*       - 2-bit duration codes for intervals of 2, 4, 6 and 8 cycles
//   NOTE_COUNT   - default number of codes captured per run
//   REF_PATTERN  - reference rhythm the capture is matched against
package rhythm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FIRST,
    ST_MEASURE,
    ST_DONE
  } state_t;

  localparam logic [1:0] CODE_2 = 2'b00;
  localparam logic [1:0] CODE_4 = 2'b01;
  localparam logic [1:0] CODE_6 = 2'b11;
  localparam logic [1:0] CODE_8 = 2'b10;

  localparam int NOTE_COUNT = 40;

  localparam logic [79:0] REF_PATTERN = 80'h42425004254150400002;

endpackage

// File: rtl/rhythm_code_map.sv
// rhythm_code_map: maps an onset-to-onset interval to its duration code.
//   n     in   4  interval in clock cycles
//   code  out  2  duration code (don't care when valid=0)
//   valid out  1  interval is one of the legal durations 2, 4, 6, 8
module rhythm_code_map
  import rhythm_pkg::*;
(
  input  logic [3:0] n,
  output logic [1:0] code,
  output logic       valid
);

  always_comb begin
    code  = CODE_2;
    valid = 1'b0;
    case (n)
      4'd2: begin code = CODE_2; valid = 1'b1; end
      4'd4: begin code = CODE_4; valid = 1'b1; end
      4'd6: begin code = CODE_6; valid = 1'b1; end
      4'd8: begin code = CODE_8; valid = 1'b1; end
      default: begin code = CODE_2; valid = 1'b0; end
    endcase
  end

endmodule

// File: rtl/rhythm_recorder.sv
// rhythm_recorder: captures a rhythm as a string of 2-bit duration codes.
// A low cycle on tick is a note onset; the spacing between consecutive
// onsets is measured and encoded. The first onset only starts timing.
//   clk4hz   in   1             clock, rising edge
//   rst      in   1             synchronous active-high reset
//   tick     in   1             onset strobe (low = onset)
//   arm      in   1             start a capture (honoured in IDLE/DONE)
//   pattern  out  2*NOTE_COUNT  captured codes, oldest in the MSBs
//   count    out  6             codes captured so far
//   busy     out  1             capture in progress
//   done     out  1             capture finished (ok or error)
//   err      out  1             run ended on illegal interval or timeout
//   match    out  1             registered done & ~err & pattern==REF
module rhythm_recorder #(
  parameter int NOTE_COUNT = rhythm_pkg::NOTE_COUNT,
  parameter int MAX_GAP    = 8
) (
  input  logic                    clk4hz,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    arm,
  output logic [2*NOTE_COUNT-1:0] pattern,
  output logic [5:0]              count,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    match
);

  import rhythm_pkg::*;

  localparam logic [2*NOTE_COUNT-1:0] REF_LOCAL = (2*NOTE_COUNT)'(REF_PATTERN);
  localparam logic [3:0]              GAP_LIMIT = 4'(MAX_GAP);
  localparam logic [5:0]              LAST_IDX  = 6'(NOTE_COUNT - 1);

  state_t     state_reg;
  logic [3:0] cnt_reg;
  logic [3:0] cnt_inc;
  logic [1:0] code;
  logic       code_valid;

  rhythm_code_map u_code_map (
    .n     (cnt_reg),
    .code  (code),
    .valid (code_valid)
  );

  // Interval counter saturates rather than wrapping.
  assign cnt_inc = (cnt_reg == 4'd15) ? 4'd15 : cnt_reg + 4'd1;

  always_ff @(posedge clk4hz) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      pattern   <= '0;
      count     <= 6'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      match     <= 1'b0;
    end else begin
      // Built from the registered flags, so it trails done by one cycle.
      match <= done & ~err & (pattern == REF_LOCAL);

      case (state_reg)
        ST_IDLE, ST_DONE: begin
          // An onset coinciding with arm is dropped: timing starts at
          // the first onset seen in WAIT_FIRST.
          if (arm) begin
            pattern   <= '0;
            count     <= 6'd0;
            err       <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
            cnt_reg   <= 4'd0;
            state_reg <= ST_WAIT_FIRST;
          end
        end

        ST_WAIT_FIRST: begin
          if (!tick) begin
            cnt_reg   <= 4'd1;
            state_reg <= ST_MEASURE;
          end
        end

        ST_MEASURE: begin
          if (!tick) begin
            if (code_valid) begin
              pattern <= {pattern[2*NOTE_COUNT-3:0], code};
              count   <= count + 6'd1;
              cnt_reg <= 4'd1;
              if (count == LAST_IDX) begin
                done      <= 1'b1;
                busy      <= 1'b0;
                state_reg <= ST_DONE;
              end
            end else begin
              err       <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b0;
              state_reg <= ST_DONE;
            end
          end else begin
            cnt_reg <= cnt_inc;
            // Counter is about to pass MAX_GAP with no onset: no legal
            // interval can follow, so end the run now.
            if (cnt_reg >= GAP_LIMIT) begin
              err       <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b0;
              state_reg <= ST_DONE;
            end
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
